vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Pixel-clock video timing generator sitting directly upstream of the HDMI/DVI output stage. It produces scan coordinates and a pixel request toward the pixel source (framebuffer/renderer). It accepts that source's colour after a fixed pipeline latency. It emits vga_hsync, vga_vsync, vga_blank and a 24-bit colour mutually aligned, ready to feed the TMDS encoder.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HSYNC_POL, 0, active level of vga_hsync (0 = active-low)
VSYNC_POL, 0, active level of vga_vsync
PIPE_LAT, 2, cycles from pix_req to color_in valid (legal 1..8)

Ports:
clk_pixel  input  1  pixel clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
pix_x  output  12  request-side column; 0..H_TOTAL-1
pix_y  output  12  request-side line; 0..V_TOTAL-1
pix_req  output  1  high when (pix_x,pix_y) is in the active area
frame_start  output  1  one-cycle pulse with request at (0,0)
color_in  input  24  pixel colour from source, PIPE_LAT cycles after pix_req
color_valid  input  1  source asserts with color_in
underflow_clr  input  1  clears sticky underflow flag
underflow  output  1  sticky: active pixel arrived without color_valid
vga_hsync  output  1  horizontal sync, polarity HSYNC_POL
vga_vsync  output  1  vertical sync, polarity VSYNC_POL
vga_blank  output  1  high outside active area
color  output  24  registered output colour, 0 when blanked

Behaviour:
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Default 800x525.
- Request stage: h_cnt increments every cycle and wraps H_TOTAL-1 -> 0. v_cnt increments on h wrap and wraps V_TOTAL-1 -> 0. pix_x = h_cnt, pix_y = v_cnt, both combinational from registers.
- pix_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). frame_start = (h_cnt==0 && v_cnt==0).
- Raw hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. Raw vsync active for whole lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. Raw active = pix_req.
- Raw {hsync, vsync, active} pass through a PIPE_LAT-deep delay line so they align with color_in.
- Output register, one further cycle:
  - vga_hsync = delayed hsync ? HSYNC_POL : ~HSYNC_POL; vga_vsync likewise.
  - vga_blank = ~delayed active.
  - color = color_in if delayed active && color_valid, else 24'h000000.
- Total latency from pix_req to the matching output is PIPE_LAT+1 cycles. Sync edges keep the same latency.
- Underflow:
  - Set when delayed active && !color_valid.
  - Cleared by underflow_clr.
  - If set and clear occur in the same cycle, set wins.
  - color_valid is ignored while blanked.
- Reset (async assert, sync-safe release):
  - h_cnt = v_cnt = 0.
  - Delay line holds {hsync inactive, vsync inactive, active=0}.
  - vga_blank = 1, syncs at inactive level, color = 0, underflow = 0.
- First cycle after release: pix_req = 1 and frame_start = 1 at (0,0).
- Reset mid-frame restarts at (0,0) with no partial sync pulse left in the pipeline.
- Counter widths are fixed at 12 bits. Parameter sets with H_TOTAL or V_TOTAL > 4096 are illegal; the simulation assertion fires.

Decomposition:
- Package vga_timing_pkg: 640x480@60 timing constants (H_*/V_* defaults), function to compute totals, COLOR_W = 24, black constant.
- Sub-module video_delay_line: parameterised width/depth shift register with async active-low reset to a parameterised reset value. Used for the sync/active pipeline.

Test Plan:
- Reset: hold resetn low 5 cycles. Require vga_blank=1, vga_hsync=vga_vsync=1, color=0, underflow=0. On release, pix_req=1 and frame_start=1 in the same cycle.
- Line timing, defaults: request-side hsync spans h_cnt 656..751. vga_hsync is low for exactly 96 cycles, falling 3 cycles after pix_x=656. Line period is 800 cycles.
- Frame timing: frame_start pulses every 420000 cycles. vga_vsync is low for 1600 cycles (lines 490-491). vga_blank has 480x640 low cycles per frame.
- Alignment: source model returns color_in={pix_x[7:0],pix_y[7:0],8'hA5} with valid, 2 cycles after pix_req. At the first non-blank output after frame_start, color=0x0000A5. Five cycles later, color=0x0500A5.
- Underflow: drop color_valid for one active pixel. Require color=0 that cycle and underflow=1 thereafter. underflow_clr coincident with another miss leaves underflow=1. A clean clear gives 0.
- Mid-line reset plus polarity: run with HSYNC_POL=1 and assert resetn at h_cnt=700. Require vga_hsync=0 immediately, and no hsync pulse until pix_x=656 of the restarted line 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the video timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned CNT_MAX = 4096;
    localparam int unsigned COLOR_W = 24;

    localparam logic [COLOR_W-1:0] COLOR_BLACK = '0;

    function automatic int unsigned calc_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with asynchronous active-low reset to RST_VAL.
module video_delay_line #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Video timing generator: scan counters on the request side, sync/active
// delayed to meet the source colour, then one aligned output register.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic               clk_pixel,
    input  logic               resetn,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               pix_req,
    output logic               frame_start,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               color_valid,
    input  logic               underflow_clr,
    output logic               underflow,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_blank,
    output logic [COLOR_W-1:0] color
);

    localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
    logic               hs_raw, vs_raw;
    logic [2:0]         dly_out;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               blank_q, blank_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               underflow_q, underflow_d;

    always_ff @(posedge clk_pixel) begin
        assert (H_TOTAL <= CNT_MAX && V_TOTAL <= CNT_MAX && PIPE_LAT >= 1 && PIPE_LAT <= 8)
            else $error("vga_timing_gen: illegal timing parameters");
    end

    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign pix_x       = h_cnt_q;
    assign pix_y       = v_cnt_q;
    assign pix_req     = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign hs_raw      = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    assign vs_raw      = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);

    // Raw syncs are active-high internally; polarity is applied at the output.
    video_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (3'b000)
    ) u_sync_dly (
        .clk_i  (clk_pixel),
        .rst_ni (resetn),
        .d_i    ({hs_raw, vs_raw, pix_req}),
        .q_o    (dly_out)
    );

    always_comb begin
        hsync_d     = dly_out[2] ? HSYNC_POL : ~HSYNC_POL;
        vsync_d     = dly_out[1] ? VSYNC_POL : ~VSYNC_POL;
        blank_d     = ~dly_out[0];
        color_d     = (dly_out[0] && color_valid) ? color_in : COLOR_BLACK;
        underflow_d = (dly_out[0] && !color_valid) || (underflow_q && !underflow_clr);
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            hsync_q     <= ~HSYNC_POL;
            vsync_q     <= ~VSYNC_POL;
            blank_q     <= 1'b1;
            color_q     <= COLOR_BLACK;
            underflow_q <= 1'b0;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            color_q     <= color_d;
            underflow_q <= underflow_d;
        end
    end

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_blank = blank_q;
    assign color     = color_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing, a polarity/mid-line-reset instance and a
// shrunken-timing instance for whole-frame checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // default instance
    logic        resetn = 1'b0;
    logic [11:0] pix_x, pix_y;
    logic        pix_req, frame_start, underflow, vga_hsync, vga_vsync, vga_blank;
    logic [23:0] color_in, color;
    logic        color_valid, underflow_clr = 1'b0, drop_req = 1'b0;

    vga_timing_gen dut (
        .clk_pixel(clk), .resetn(resetn), .pix_x(pix_x), .pix_y(pix_y),
        .pix_req(pix_req), .frame_start(frame_start), .color_in(color_in),
        .color_valid(color_valid), .underflow_clr(underflow_clr), .underflow(underflow),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank), .color(color)
    );

    // source model: two-cycle latency from request to colour
    logic [23:0] c1 = '0, c2 = '0;
    logic        v1 = 1'b1, v2 = 1'b1;
    always @(posedge clk) begin
        c1 <= {pix_x[7:0], pix_y[7:0], 8'hA5};
        c2 <= c1;
        v1 <= ~drop_req;
        v2 <= v1;
    end
    assign color_in    = c2;
    assign color_valid = v2;

    // active-high hsync instance, reset mid-line
    logic        resetn_p = 1'b0;
    logic [11:0] pix_x_p, pix_y_p;
    logic        pix_req_p, frame_start_p, underflow_p, vga_hsync_p, vga_vsync_p, vga_blank_p;
    logic [23:0] color_p;

    vga_timing_gen #(.HSYNC_POL(1'b1)) dut_p (
        .clk_pixel(clk), .resetn(resetn_p), .pix_x(pix_x_p), .pix_y(pix_y_p),
        .pix_req(pix_req_p), .frame_start(frame_start_p), .color_in(24'h0),
        .color_valid(1'b1), .underflow_clr(1'b0), .underflow(underflow_p),
        .vga_hsync(vga_hsync_p), .vga_vsync(vga_vsync_p), .vga_blank(vga_blank_p), .color(color_p)
    );

    // 16x8 total timing, 8x4 active: frame = 128 cycles
    logic [11:0] pix_x_s, pix_y_s;
    logic        pix_req_s, frame_start_s, underflow_s, vga_hsync_s, vga_vsync_s, vga_blank_s;
    logic [23:0] color_s;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk_pixel(clk), .resetn(resetn), .pix_x(pix_x_s), .pix_y(pix_y_s),
        .pix_req(pix_req_s), .frame_start(frame_start_s), .color_in(24'hFFFFFF),
        .color_valid(1'b1), .underflow_clr(1'b0), .underflow(underflow_s),
        .vga_hsync(vga_hsync_s), .vga_vsync(vga_vsync_s), .vga_blank(vga_blank_s), .color(color_s)
    );

    int hs_first = -1, hs_cnt = 0;
    int p_first = -1, p_cnt = 0;
    int fs_prev = -1, vs_low = 0, act_cnt = 0;

    initial begin
        repeat (5) @(negedge clk);
        check("rst_blank", vga_blank, 1);
        check("rst_hsync", vga_hsync, 1);
        check("rst_vsync", vga_vsync, 1);
        check("rst_color", color, 0);
        check("rst_underflow", underflow, 0);
        resetn   = 1'b1;
        resetn_p = 1'b1;
        #1;
        check("rel_pix_req", pix_req, 1);
        check("rel_frame_start", frame_start, 1);

        for (int k = 0; k <= 1400; k++) begin
            drop_req      = (k == 810) || (k == 830);
            underflow_clr = (k == 832) || (k == 840);
            if (k == 702) resetn_p = 1'b1;

            case (k)
                2:    check("blank_before_first", vga_blank, 1);
                3:    begin
                          check("first_blank", vga_blank, 0);
                          check("first_color", color, 24'h0000A5);
                      end
                8:    check("color_x5", color, 24'h0500A5);
                639:  check("req_x639", pix_req, 1);
                640:  check("req_x640", pix_req, 0);
                642:  check("color_x639", color, 24'h7F00A5);
                643:  begin
                          check("blank_x640", vga_blank, 1);
                          check("color_blanked", color, 0);
                      end
                800:  begin
                          check("wrap_x", pix_x, 0);
                          check("wrap_y", pix_y, 1);
                          check("wrap_fs", frame_start, 0);
                      end
                812:  check("uf_before", underflow, 0);
                813:  begin
                          check("uf_color", color, 0);
                          check("uf_set", underflow, 1);
                      end
                814:  check("uf_next_color", color, 24'h0B01A5);
                833:  check("uf_clr_vs_set", underflow, 1);
                840:  check("uf_held", underflow, 1);
                841:  check("uf_cleared", underflow, 0);
                1000: check("vsync_idle", vga_vsync, 1);
                1358: check("p_x656", pix_x_p, 656);
                default: ;
            endcase

            if (!vga_hsync) begin
                if (hs_first < 0) hs_first = k;
                hs_cnt++;
            end

            if (k == 700) begin
                check("p_hsync_pre", vga_hsync_p, 1);
                resetn_p = 1'b0;
                #1;
                check("p_hsync_rst", vga_hsync_p, 0);
                check("p_x_rst", pix_x_p, 0);
            end else if (k > 700 && vga_hsync_p) begin
                if (p_first < 0) p_first = k;
                p_cnt++;
            end

            if (frame_start_s) begin
                if (fs_prev >= 0) check("s_frame_period", k - fs_prev, 128);
                fs_prev = k;
            end
            if (k >= 128 && k < 256) begin
                if (!vga_vsync_s) vs_low++;
                if (!vga_blank_s) act_cnt++;
            end

            @(negedge clk);
        end

        check("hsync_first_low", hs_first, 659);
        check("hsync_width", hs_cnt, 96);
        check("p_first_high", p_first, 1361);
        check("p_high_cnt", p_cnt, 40);
        check("s_last_frame", fs_prev, 1280);
        check("s_vsync_low", vs_low, 32);
        check("s_active_cnt", act_cnt, 32);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
